// File: rtl/pulse_train_pkg.sv
// Shared constants and helpers for the pulse train generator.
// State codes, state width and the zero-substitute helper.
package pulse_train_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_GAP   = 2'd1;
  localparam logic [STATE_W-1:0] S_PULSE = 2'd2;

  // A programmed length of zero behaves as one.
  function automatic logic [31:0] zsub(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle of the pulse train generator.
// Master drives START/STOP and lengths, slave returns status.
interface pulse_train_gen_if #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
);

  logic               start;
  logic               stop;
  logic [CNT_W-1:0]   gap_len;
  logic [CNT_W-1:0]   pulse_len;
  logic [BURST_W-1:0] burst_len;
  logic               idle;
  logic               pre_pulse;
  logic               pulse;
  logic               done;

  modport master (
    output start, stop, gap_len, pulse_len, burst_len,
    input  idle, pre_pulse, pulse, done
  );

  modport slave (
    input  start, stop, gap_len, pulse_len, burst_len,
    output idle, pre_pulse, pulse, done
  );

endinterface

// File: rtl/pulse_len_counter.sv
// Loadable down-counter with zero flag.
// Shared between the gap and pulse phases.
module pulse_len_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // load wins over decrement; count parks at zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Burst pulse train generator: gap / pulse / repeat.
// Optional PULSE_TRAIN_GEN_CONTINUOUS_EN: BURST_LEN=0 runs until STOP.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input logic              clk,
  input logic              rstn,
  pulse_train_gen_if.slave bus
);

  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   g_len;
  logic [CNT_W-1:0]   p_len;
  logic [BURST_W-1:0] remaining;
  logic               stop_seen;
  logic               cont;

  logic [CNT_W-1:0]   g_eff;
  logic [CNT_W-1:0]   p_eff;
  logic [BURST_W-1:0] n_eff;

  logic               cnt_zero;
  logic               cnt_load;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt_val;

  logic               launch;
  logic               gap_end;
  logic               more;
  logic               next_gap;

  assign g_eff = CNT_W'(zsub(32'(bus.gap_len)));
  assign p_eff = CNT_W'(zsub(32'(bus.pulse_len)));

`ifdef PULSE_TRAIN_GEN_CONTINUOUS_EN
  assign n_eff = bus.burst_len;

  // zero burst length selects free-running mode
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cont <= 1'b0;
    end else if (launch) begin
      cont <= (bus.burst_len == '0);
    end
  end
`else
  assign n_eff = BURST_W'(zsub(32'(bus.burst_len)));
  assign cont  = 1'b0;
`endif

  assign launch   = (state == S_IDLE) && bus.start && !bus.stop;
  assign gap_end  = (state == S_GAP) && cnt_zero && !bus.stop;
  assign more     = cont || (remaining > BURST_W'(1));
  assign next_gap = (state == S_PULSE) && cnt_zero && more
                    && !stop_seen && !bus.stop;

  assign cnt_load = launch || gap_end || next_gap;
  assign cnt_dec  = (state != S_IDLE);

  // reload value for the phase about to start
  always_comb begin
    cnt_val = g_len;
    if (launch) begin
      cnt_val = g_eff - CNT_W'(1);
    end else if (gap_end) begin
      cnt_val = p_len;
    end
  end

  pulse_len_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // phase sequencing, burst count and sticky abort
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      g_len     <= '0;
      p_len     <= '0;
      remaining <= '0;
      stop_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            state     <= S_GAP;
            g_len     <= g_eff - CNT_W'(1);
            p_len     <= p_eff - CNT_W'(1);
            remaining <= n_eff;
            stop_seen <= 1'b0;
          end
        end
        S_GAP: begin
          if (bus.stop) begin
            state <= S_IDLE;
          end else if (cnt_zero) begin
            state <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (cnt_zero) begin
            stop_seen <= 1'b0;
            if (next_gap) begin
              state <= S_GAP;
              if (!cont) begin
                remaining <= remaining - BURST_W'(1);
              end
            end else begin
              state <= S_IDLE;
            end
          end else if (bus.stop) begin
            stop_seen <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.idle      = (state == S_IDLE);
  assign bus.pre_pulse = (state == S_GAP) && cnt_zero;
  assign bus.pulse     = (state == S_PULSE);
  assign bus.done      = (state == S_PULSE) && cnt_zero && !cont
                         && (remaining == BURST_W'(1)) && !stop_seen;

endmodule
